// File: rtl/d_sram2axi.sv
// d_sram2axi: single-outstanding bridge from the data-side sram-like bus to one AXI master port.
// Optional response checking: define D_SRAM2AXI_ERRCHK_EN to drive bus_err from SLVERR/DECERR.
module d_sram2axi #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic [DATA_W-1:0] data_rdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [ADDR_W-1:0] araddr,
    output logic [2:0]        arsize,
    output logic              arvalid,
    input  logic              arready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready,
    output logic [ADDR_W-1:0] awaddr,
    output logic [2:0]        awsize,
    output logic              awvalid,
    input  logic              awready,
    output logic [DATA_W-1:0] wdata,
    output logic [3:0]        wstrb,
    output logic              wlast,
    output logic              wvalid,
    input  logic              wready,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready,
    output logic              bus_err
);
    typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AWW, S_B} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic              dok_q, dok_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;
    logic [3:0]        strb_new;

    // size 3 has no meaning on a 32-bit bus; it strobes the full word
    always_comb begin
        case (data_size)
            2'd0:    strb_new = 4'b0001 << data_addr[1:0];
            2'd1:    strb_new = data_addr[1] ? 4'b1100 : 4'b0011;
            default: strb_new = 4'b1111;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        size_d    = size_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        wstrb_d   = wstrb_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        dok_d     = 1'b0;
        case (state_q)
            S_IDLE: if (data_req) begin
                addr_d    = data_addr;
                size_d    = data_size;
                wdata_d   = data_wdata;
                wstrb_d   = strb_new;
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                state_d   = data_wr ? S_AWW : S_AR;
            end
            S_AR: if (arready) state_d = S_R;
            S_R: if (rvalid) begin
                rdata_d = rdata;
                dok_d   = 1'b1;
                state_d = S_IDLE;
            end
            S_AWW: begin
                // AW and W retire independently; B waits for both
                if (awready) aw_done_d = 1'b1;
                if (wready)  w_done_d  = 1'b1;
                if (aw_done_d && w_done_d) state_d = S_B;
            end
            S_B: if (bvalid) begin
                dok_d   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            size_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            wstrb_q   <= '0;
            dok_q     <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            size_q    <= size_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            wstrb_q   <= wstrb_d;
            dok_q     <= dok_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    assign data_addr_ok = rst & (state_q == S_IDLE) & data_req;
    assign data_data_ok = dok_q;
    assign data_rdata   = rdata_q;
    assign araddr       = addr_q;
    assign arsize       = {1'b0, size_q};
    assign arvalid      = (state_q == S_AR);
    assign rready       = (state_q == S_R);
    assign awaddr       = addr_q;
    assign awsize       = {1'b0, size_q};
    assign awvalid      = (state_q == S_AWW) & ~aw_done_q;
    assign wdata        = wdata_q;
    assign wstrb        = wstrb_q;
    assign wlast        = 1'b1;
    assign wvalid       = (state_q == S_AWW) & ~w_done_q;
    assign bready       = (state_q == S_B);

`ifdef D_SRAM2AXI_ERRCHK_EN
    logic err_q;

    // resp[1] set means SLVERR or DECERR
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) err_q <= 1'b0;
        else      err_q <= err_q | ((state_q == S_R) & rvalid & rresp[1])
                                 | ((state_q == S_B) & bvalid & bresp[1]);
    end
    assign bus_err = err_q;
`else
    logic unused_resp;
    assign unused_resp = ^{rresp, bresp};
    assign bus_err     = 1'b0;
`endif
endmodule

// File: tb/tb_d_sram2axi.sv
// tb_d_sram2axi: table vectors, hand-written corner sequences and random traffic for d_sram2axi,
// checked against a byte-level memory model and per-channel latency arithmetic.
module tb_d_sram2axi;
`ifdef D_SRAM2AXI_ERRCHK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic [2:0]  arsize, awsize;
    logic        arvalid, arready, rvalid, rready;
    logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic [1:0]  rresp, bresp;
    logic [3:0]  wstrb;
    logic        bus_err;

    d_sram2axi #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_rdata(data_rdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok),
        .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] smem [logic [29:0]];  // slave-side memory, written only through AXI
    logic [31:0] emem [logic [29:0]];  // expected memory, written from sram-like requests
    bit          pending_dok = 1'b0;
    bit          err_model   = 1'b0;
    logic [31:0] last_rd     = 32'h0;

    typedef struct {
        bit          wr;
        logic [1:0]  sz;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [3:0]  strb;
        logic [31:0] rd;
    } vec_t;
    vec_t tbl [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] s_get(input logic [29:0] w);
        return smem.exists(w) ? smem[w] : 32'h0;
    endfunction

    function automatic logic [31:0] e_get(input logic [29:0] w);
        return emem.exists(w) ? emem[w] : 32'h0;
    endfunction

    task automatic clear_slave();
        arready = 1'b0; rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    endtask

    // Acts as both sram-like master and AXI slave. Entered and left at posedge+1.
    task automatic run_txn(input bit wr, input logic [1:0] sz, input logic [31:0] a,
                           input logic [31:0] wd, input int lar, input int lr, input int law,
                           input int lw, input int lb, input logic [1:0] resp, input bit b2b,
                           input string tag, output logic [3:0] got_strb, output logic [31:0] got_rd);
        int cyc, car, cr, caw, cw, cb, nb, lo, exp_lat, stray;
        bit har, hr, haw, hw, hb, done;
        logic [29:0] wa;
        logic [31:0] exp_rd, ew, cap_wd, cap_aw;
        logic [3:0]  es, cap_strb;
        car = 0; cr = 0; caw = 0; cw = 0; cb = 0; stray = 0;
        har = 0; hr = 0; haw = 0; hw = 0; hb = 0; done = 0;
        cap_wd = '0; cap_aw = '0; cap_strb = '0; got_strb = '0; got_rd = '0; es = '0;
        wa = a[31:2];
        exp_lat = wr ? 3 + ((law > lw) ? law : lw) + lb : 3 + lar + lr;
        exp_rd = e_get(wa);
        if (wr) begin
            nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
            lo = int'(a[1:0]);
            lo = lo - (lo % nb);
            ew = e_get(wa);
            for (int b = 0; b < 4; b++)
                if (b >= lo && b < lo + nb) begin
                    ew[b*8 +: 8] = wd[b*8 +: 8];
                    es[b] = 1'b1;
                end
            emem[wa] = ew;
        end
        data_req = 1'b1; data_wr = wr; data_size = sz; data_addr = a; data_wdata = wd;
        #1;
        check({tag, "/addr_ok"}, 32'(data_addr_ok), 32'd1);
        if (pending_dok) check({tag, "/b2b_dok"}, 32'(data_data_ok), 32'd1);
        @(posedge clk); #1;
        data_req = 1'b0;
        cyc = 1;
        while (!done && cyc <= 80) begin
            if (wr ? hb : hr) begin
                clear_slave();
                got_rd = data_rdata;
                check({tag, "/dok"}, 32'(data_data_ok), 32'd1);
                check({tag, "/rdata"}, data_rdata, wr ? last_rd : exp_rd);
                check({tag, "/lat"}, 32'(cyc), 32'(exp_lat));
                check({tag, "/bus_err"}, 32'(bus_err), 32'(err_model));
                done = 1;
            end else begin
                if (data_data_ok) stray++;
                arready = arvalid && (car >= lar);
                rvalid  = har && !hr && (cr >= lr);
                rdata   = s_get(wa);
                rresp   = resp;
                awready = awvalid && (caw >= law);
                wready  = wvalid && (cw >= lw);
                bvalid  = haw && hw && !hb && (cb >= lb);
                bresp   = resp;
                #1;
                if (wr) begin
                    if (arvalid || rready) stray++;
                    if (awvalid == haw) stray++;
                    if (wvalid == hw) stray++;
                    if (bready != (haw && hw)) stray++;
                end else begin
                    if (awvalid || wvalid || bready) stray++;
                    if (arvalid == har) stray++;
                    if (rready != har) stray++;
                end
                if (har && !hr) cr++;
                if (haw && hw && !hb) cb++;
                if (arvalid) car++;
                if (awvalid) caw++;
                if (wvalid) cw++;
                if (arvalid && arready) begin
                    check({tag, "/araddr"}, araddr, a);
                    check({tag, "/arsize"}, 32'(arsize), 32'({1'b0, sz}));
                    har = 1;
                end
                if (rvalid && rready) begin
                    hr = 1;
                    if (ERR_EN && resp[1]) err_model = 1'b1;
                end
                if (awvalid && awready) begin
                    check({tag, "/awaddr"}, awaddr, a);
                    check({tag, "/awsize"}, 32'(awsize), 32'({1'b0, sz}));
                    cap_aw = awaddr;
                    haw = 1;
                end
                if (wvalid && wready) begin
                    check({tag, "/wstrb"}, 32'(wstrb), 32'(es));
                    check({tag, "/wdata"}, wdata, wd);
                    check({tag, "/wlast"}, 32'(wlast), 32'd1);
                    cap_wd = wdata; cap_strb = wstrb; got_strb = wstrb;
                    hw = 1;
                end
                if (bvalid && bready) begin
                    ew = s_get(cap_aw[31:2]);
                    for (int b = 0; b < 4; b++)
                        if (cap_strb[b]) ew[b*8 +: 8] = cap_wd[b*8 +: 8];
                    smem[cap_aw[31:2]] = ew;
                    if (ERR_EN && resp[1]) err_model = 1'b1;
                    hb = 1;
                end
                @(posedge clk); #1;
                cyc++;
            end
        end
        clear_slave();
        if (!wr && done) last_rd = exp_rd;
        check({tag, "/done"}, 32'(done), 32'd1);
        check({tag, "/stray"}, 32'(stray), 32'd0);
        pending_dok = b2b;
        if (!b2b) begin
            @(posedge clk); #1;
            check({tag, "/dok_pulse"}, 32'(data_data_ok), 32'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [3:0]  gs;
        logic [31:0] gr;
        bit          b2b;
        rst = 1'b0; data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2;
        data_addr = 32'h0; data_wdata = 32'h0; rdata = 32'h0; rresp = 2'd0; bresp = 2'd0;
        clear_slave();
        #2;
        check("rst/addr_ok", 32'(data_addr_ok), 32'd0);
        check("rst/valids", 32'({arvalid, rready, awvalid, wvalid, bready}), 32'd0);
        check("rst/dok_err", 32'({data_data_ok, bus_err}), 32'd0);
        check("rst/regs", araddr | data_rdata | wdata | 32'(wstrb), 32'd0);
        data_req = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;

        smem[30'(32'h1FC0_0010 >> 2)] = 32'hDEAD_BEEF;
        emem[30'(32'h1FC0_0010 >> 2)] = 32'hDEAD_BEEF;
        tbl[0]  = '{0, 2'd2, 32'h1FC0_0010, 32'h0,         4'h0, 32'hDEAD_BEEF};
        tbl[1]  = '{1, 2'd0, 32'h8000_0003, 32'hAA00_0000, 4'h8, 32'h0};
        tbl[2]  = '{0, 2'd2, 32'h8000_0000, 32'h0,         4'h0, 32'hAA00_0000};
        tbl[3]  = '{1, 2'd1, 32'h8000_0002, 32'h5566_0000, 4'hC, 32'h0};
        tbl[4]  = '{0, 2'd2, 32'h8000_0000, 32'h0,         4'h0, 32'h5566_0000};
        tbl[5]  = '{1, 2'd1, 32'h8000_0000, 32'h0000_7788, 4'h3, 32'h0};
        tbl[6]  = '{0, 2'd2, 32'h8000_0000, 32'h0,         4'h0, 32'h5566_7788};
        tbl[7]  = '{1, 2'd0, 32'h8000_0001, 32'h0000_CC00, 4'h2, 32'h0};
        tbl[8]  = '{0, 2'd2, 32'h8000_0000, 32'h0,         4'h0, 32'h5566_CC88};
        tbl[9]  = '{1, 2'd3, 32'h8000_0004, 32'h1234_5678, 4'hF, 32'h0};
        tbl[10] = '{0, 2'd0, 32'h8000_0006, 32'h0,         4'h0, 32'h1234_5678};
        for (int i = 0; i < 11; i++) begin
            run_txn(tbl[i].wr, tbl[i].sz, tbl[i].addr, tbl[i].wd, 0, 0, 0, 0, 0, 2'd0, 1'b0,
                    $sformatf("tbl%0d", i), gs, gr);
            if (tbl[i].wr) check($sformatf("tbl%0d/strb_vec", i), 32'(gs), 32'(tbl[i].strb));
            else           check($sformatf("tbl%0d/rd_vec", i), gr, tbl[i].rd);
        end

        // W handshakes long before AW, then the opposite order with a slow B
        run_txn(1, 2'd1, 32'h8000_0002, 32'hBEEF_0000, 0, 0, 4, 0, 0, 2'd0, 1'b0, "aw_late", gs, gr);
        check("aw_late/strb_vec", 32'(gs), 32'hC);
        run_txn(1, 2'd2, 32'h8000_0008, 32'h0BAD_F00D, 0, 0, 0, 3, 2, 2'd0, 1'b0, "w_late", gs, gr);

        // read then write with the next request already waiting on the completion cycle
        run_txn(0, 2'd2, 32'h8000_0008, 32'h0, 1, 2, 0, 0, 0, 2'd0, 1'b1, "b2b_rd", gs, gr);
        check("b2b_rd/rd_vec", gr, 32'h0BAD_F00D);
        run_txn(1, 2'd2, 32'h8000_000C, 32'hCAFE_0001, 0, 0, 0, 0, 0, 2'd0, 1'b0, "b2b_wr", gs, gr);

        // error responses: bus_err follows the build option and is sticky
        run_txn(1, 2'd2, 32'h8000_0010, 32'h1111_2222, 0, 0, 0, 0, 0, 2'd2, 1'b0, "err_b", gs, gr);
        run_txn(0, 2'd2, 32'h8000_0010, 32'h0, 0, 0, 0, 0, 0, 2'd0, 1'b0, "err_hold", gs, gr);
        check("err_hold/rd_vec", gr, 32'h1111_2222);
        run_txn(0, 2'd2, 32'h8000_000C, 32'h0, 0, 1, 0, 0, 0, 2'd3, 1'b0, "err_r", gs, gr);

        // reset while waiting for R
        data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h8000_0014;
        #1 check("rstR/addr_ok", 32'(data_addr_ok), 32'd1);
        @(posedge clk); #1;
        data_req = 1'b0; arready = 1'b1;
        #1 check("rstR/arvalid", 32'(arvalid), 32'd1);
        @(posedge clk); #1;
        arready = 1'b0;
        check("rstR/in_R", 32'(rready), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("rstR/valids", 32'({arvalid, rready, awvalid, wvalid, bready}), 32'd0);
        check("rstR/rdata", data_rdata, 32'h0);
        check("rstR/bus_err", 32'(bus_err), 32'd0);
        repeat (3) begin
            @(posedge clk); #1;
            check("rstR/no_dok", 32'(data_data_ok), 32'd0);
        end
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        err_model = 1'b0; last_rd = 32'h0; pending_dok = 1'b0;
        run_txn(1, 2'd2, 32'h8000_0014, 32'h7777_8888, 0, 0, 0, 0, 0, 2'd0, 1'b0, "post_rst_w", gs, gr);
        run_txn(0, 2'd2, 32'h8000_0014, 32'h0, 0, 0, 0, 0, 0, 2'd0, 1'b0, "post_rst_r", gs, gr);

        // random traffic over a small window so reads hit earlier writes
        b2b = 1'b0;
        for (int i = 0; i < 300; i++) begin
            b2b = ($urandom_range(0, 2) == 0);
            run_txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    32'h8000_0000 | 32'($urandom_range(0, 31)), $urandom,
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 3), 2'($urandom_range(0, 3)),
                    b2b, $sformatf("rnd%0d", i), gs, gr);
            if (!b2b) repeat ($urandom_range(0, 2)) @(posedge clk);
            if (!b2b) #1;
        end
        if (b2b) begin
            @(posedge clk); #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
